// File: rtl/ibex_wb_pkg.sv
// Shared types for the writeback stage: the buffered result entry and the
// forwarding lookup used for both decode operands.
package ibex_wb_pkg;

    localparam int unsigned WbFifoDepth = 2;
    localparam int unsigned WbDataWidth = 32;

    typedef struct packed {
        logic                   valid;
        logic [4:0]             waddr;
        logic [WbDataWidth-1:0] wdata;
    } wb_entry_t;

    function automatic logic wb_rd_match(wb_entry_t e, logic [4:0] raddr);
        return e.valid && (e.waddr == raddr) && (raddr != 5'd0);
    endfunction

    // Newest match wins; result is {valid, data}, all-zero when nothing matches.
    function automatic logic [WbDataWidth:0] wb_forward(wb_entry_t tail, wb_entry_t head,
                                                        wb_entry_t outr, logic [4:0] raddr);
        logic [WbDataWidth:0] res;
        res = '0;
        if (wb_rd_match(tail, raddr)) begin
            res = {1'b1, tail.wdata};
        end else if (wb_rd_match(head, raddr)) begin
            res = {1'b1, head.wdata};
        end else if (wb_rd_match(outr, raddr)) begin
            res = {1'b1, outr.wdata};
        end
        return res;
    endfunction

endpackage

// File: rtl/ibex_wb_fifo.sv
// Two-entry in-order FIFO of execute results; entry contents are exposed so
// the writeback stage can forward from them.
module ibex_wb_fifo
    import ibex_wb_pkg::*;
(
    input  logic      clk_int,
    input  logic      rst_ni,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output wb_entry_t tail_o,
    output logic      full_o,
    output logic      empty_o
);

    wb_entry_t mem_q [WbFifoDepth];
    wb_entry_t mem_d [WbFifoDepth];
    logic      wr_ptr_q, wr_ptr_d;
    logic      rd_ptr_q, rd_ptr_d;
    logic      tail_idx;

    // Pop clears the slot before push refills it, so push+pop at full is safe.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (pop_i) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = ~rd_ptr_q;
        end
        if (push_i) begin
            mem_d[wr_ptr_q]       = push_entry_i;
            mem_d[wr_ptr_q].valid = 1'b1;
            wr_ptr_d              = ~wr_ptr_q;
        end
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign tail_idx = ~wr_ptr_q;
    assign head_o   = mem_q[rd_ptr_q];
    assign tail_o   = mem_q[tail_idx];
    assign full_o   = mem_q[0].valid && mem_q[1].valid;
    assign empty_o  = !mem_q[rd_ptr_q].valid;

endmodule

// File: rtl/ibex_rf_wb_stage.sv
// Writeback stage: merges buffered execute results and late load responses
// onto the registered RF write port, with forwarding and load-use stall.
module ibex_rf_wb_stage
    import ibex_wb_pkg::*;
#(
    parameter int unsigned DataWidth = WbDataWidth,
    parameter bit          RV32E     = 1'b0
) (
    input  logic                 clk_int,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_req_i,
    input  logic [4:0]           lsu_waddr_i,
    output logic                 lsu_req_ready_o,
    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 fwd_a_valid_o,
    output logic [DataWidth-1:0] fwd_a_data_o,
    output logic                 fwd_b_valid_o,
    output logic [DataWidth-1:0] fwd_b_data_o,
    output logic                 stall_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 err_o
);

    wb_entry_t            fifo_head, fifo_tail, ex_entry;
    wb_entry_t            out_q, out_d;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                 load_pending_q, load_pending_d;
    logic [4:0]           load_rd_q, load_rd_d;
    logic                 err_q, err_d;
    logic                 lsu_wr, lsu_accept, ex_accept, ex_illegal, ex_keep;
    logic [WbDataWidth:0] fwd_a, fwd_b;

    assign lsu_wr     = lsu_rvalid_i && load_pending_q && !lsu_err_i && (load_rd_q != 5'd0);
    assign fifo_pop   = !fifo_empty && !lsu_wr;
    assign ex_ready_o = !(fifo_full && !fifo_pop) && !(load_pending_q && (ex_waddr_i == load_rd_q));
    assign ex_accept  = ex_valid_i && ex_ready_o;
    assign ex_illegal = RV32E && ex_waddr_i[4];
    assign ex_keep    = ex_accept && !ex_illegal && (ex_waddr_i != 5'd0);
    // An empty FIFO with a free write port lets the result go straight to the output register.
    assign fifo_push  = ex_keep && !(fifo_empty && !lsu_wr);
    assign ex_entry   = '{valid: 1'b1, waddr: ex_waddr_i, wdata: ex_wdata_i};

    ibex_wb_fifo u_fifo (
        .clk_int      (clk_int),
        .rst_ni       (rst_ni),
        .push_i       (fifo_push),
        .push_entry_i (ex_entry),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .tail_o       (fifo_tail),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_comb begin
        out_d       = out_q;
        out_d.valid = 1'b0;
        if (lsu_wr) begin
            out_d = '{valid: 1'b1, waddr: load_rd_q, wdata: lsu_rdata_i};
        end else if (fifo_pop) begin
            out_d = fifo_head;
        end else if (ex_keep) begin
            out_d = ex_entry;
        end
    end

    // Same-rd hazards are blocked here so load and execute writes never reorder.
    assign lsu_req_ready_o = !load_pending_q
                          && !wb_rd_match(fifo_head, lsu_waddr_i)
                          && !wb_rd_match(fifo_tail, lsu_waddr_i)
                          && !wb_rd_match(out_q, lsu_waddr_i);
    assign lsu_accept      = lsu_req_i && lsu_req_ready_o;

    always_comb begin
        load_pending_d = load_pending_q;
        load_rd_d      = load_rd_q;
        if (lsu_accept) begin
            load_pending_d = 1'b1;
            load_rd_d      = lsu_waddr_i;
        end else if (lsu_rvalid_i) begin
            load_pending_d = 1'b0;
        end
    end

    assign err_d = (ex_accept && ex_illegal) || (lsu_rvalid_i && !load_pending_q);

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q          <= '0;
            load_pending_q <= 1'b0;
            load_rd_q      <= 5'd0;
            err_q          <= 1'b0;
        end else begin
            out_q          <= out_d;
            load_pending_q <= load_pending_d;
            load_rd_q      <= load_rd_d;
            err_q          <= err_d;
        end
    end

    assign fwd_a         = wb_forward(fifo_tail, fifo_head, out_q, raddr_a_i);
    assign fwd_b         = wb_forward(fifo_tail, fifo_head, out_q, raddr_b_i);
    assign fwd_a_valid_o = fwd_a[WbDataWidth];
    assign fwd_a_data_o  = fwd_a[WbDataWidth-1:0];
    assign fwd_b_valid_o = fwd_b[WbDataWidth];
    assign fwd_b_data_o  = fwd_b[WbDataWidth-1:0];

    assign stall_o = load_pending_q && (((raddr_a_i == load_rd_q) && (raddr_a_i != 5'd0))
                                     || ((raddr_b_i == load_rd_q) && (raddr_b_i != 5'd0)));

    assign rf_we_o    = out_q.valid;
    assign rf_waddr_o = out_q.waddr;
    assign rf_wdata_o = out_q.wdata;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ibex_rf_wb_stage.sv
// Scoreboard bench for ibex_rf_wb_stage: in-order queue model of pending
// execute results plus a single outstanding load, randomized and directed.
module tb_ibex_rf_wb_stage;

    logic        clk_int = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i, lsu_req_i, lsu_rvalid_i, lsu_err_i;
    logic [4:0]  ex_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
    logic [31:0] ex_wdata_i, lsu_rdata_i;
    logic        ex_ready_o, lsu_req_ready_o, fwd_a_valid_o, fwd_b_valid_o;
    logic        stall_o, rf_we_o, err_o;
    logic [31:0] fwd_a_data_o, fwd_b_data_o, rf_wdata_o;
    logic [4:0]  rf_waddr_o;

    always #5 clk_int = ~clk_int;

    ibex_rf_wb_stage #(.DataWidth(32), .RV32E(1'b1)) dut (
        .clk_int(clk_int), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready_o),
        .lsu_req_i(lsu_req_i), .lsu_waddr_i(lsu_waddr_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_err_i(lsu_err_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .fwd_a_valid_o(fwd_a_valid_o), .fwd_a_data_o(fwd_a_data_o),
        .fwd_b_valid_o(fwd_b_valid_o), .fwd_b_data_o(fwd_b_data_o),
        .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    // Model: results accepted but not yet seen on the RF port, in order.
    wr_t         alu_q[$];
    bit          pend;
    logic [4:0]  prd;
    bit          lsu_due;
    wr_t         lsu_exp;
    bit          err_due;
    bit          cur_we;
    wr_t         cur;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the RF port must carry the due load response, else the oldest queued result.
    initial begin
        bit  exp_we;
        wr_t e;
        forever begin
            @(negedge clk_int);
            e = '0;
            if (lsu_due) begin
                exp_we  = 1'b1;
                e       = lsu_exp;
                lsu_due = 1'b0;
            end else if (alu_q.size() > 0) begin
                exp_we = 1'b1;
                e      = alu_q.pop_front();
            end else begin
                exp_we = 1'b0;
            end
            chk("rf_we", 64'(rf_we_o), 64'(exp_we));
            if (exp_we) begin
                chk("rf_waddr", 64'(rf_waddr_o), 64'(e.rd));
                chk("rf_wdata", 64'(rf_wdata_o), 64'(e.data));
            end
            chk("err", 64'(err_o), 64'(err_due));
            err_due = 1'b0;
            cur_we  = exp_we;
            cur     = e;
        end
    end

    function automatic logic [32:0] exp_fwd(input logic [4:0] a);
        if (a == 5'd0) return '0;
        for (int i = alu_q.size() - 1; i >= 0; i--) begin
            if (alu_q[i].rd == a) return {1'b1, alu_q[i].data};
        end
        if (cur_we && cur.rd == a) return {1'b1, cur.data};
        return '0;
    endfunction

    task automatic step(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                        input logic rq, input logic [4:0] la,
                        input logic rv, input logic [31:0] rdat, input logic rerr,
                        input logic [4:0] ra, input logic [4:0] rb);
        bit          lsu_wr_now, rdy_exp, lrdy_exp, stall_exp;
        logic [32:0] fa, fb;
        @(posedge clk_int);
        #1;
        ex_valid_i = ev; ex_waddr_i = ea; ex_wdata_i = ed;
        lsu_req_i = rq; lsu_waddr_i = la;
        lsu_rvalid_i = rv; lsu_rdata_i = rdat; lsu_err_i = rerr;
        raddr_a_i = ra; raddr_b_i = rb;
        @(negedge clk_int);
        #1;
        lsu_wr_now = rv && pend && !rerr && (prd != 5'd0);
        rdy_exp    = !(alu_q.size() == 2 && lsu_wr_now) && !(pend && ea == prd);
        lrdy_exp   = !pend && !(cur_we && cur.rd == la);
        foreach (alu_q[i]) if (alu_q[i].rd == la) lrdy_exp = 1'b0;
        stall_exp  = pend && ((ra == prd && ra != 0) || (rb == prd && rb != 0));
        fa = exp_fwd(ra);
        fb = exp_fwd(rb);
        chk("ex_ready", 64'(ex_ready_o), 64'(rdy_exp));
        chk("lsu_req_ready", 64'(lsu_req_ready_o), 64'(lrdy_exp));
        chk("stall", 64'(stall_o), 64'(stall_exp));
        chk("fwd_a", {31'd0, fwd_a_valid_o, fwd_a_data_o}, 64'(fa));
        chk("fwd_b", {31'd0, fwd_b_valid_o, fwd_b_data_o}, 64'(fb));
        if (ev && rdy_exp) begin
            if (ea[4]) err_due = 1'b1;
            else if (ea != 5'd0) alu_q.push_back('{rd: ea, data: ed});
        end
        if (rv && !pend) err_due = 1'b1;
        if (lsu_wr_now) begin
            lsu_due = 1'b1;
            lsu_exp = '{rd: prd, data: rdat};
        end
        if (rq && lrdy_exp) begin
            pend = 1'b1;
            prd  = la;
        end else if (rv) begin
            pend = 1'b0;
        end
    endtask

    task automatic idle(input int n, input logic [4:0] ra = 5'd0);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, ra, 0);
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d, input logic rv = 0,
                       input logic [31:0] rdat = 0, input logic rq = 0, input logic [4:0] la = 0);
        step(1, a, d, rq, la, rv, rdat, 0, 0, 0);
    endtask

    task automatic drive_idle();
        ex_valid_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
        lsu_req_i = 0; lsu_waddr_i = 0; lsu_rvalid_i = 0; lsu_rdata_i = 0; lsu_err_i = 0;
        raddr_b_i = 0;
    endtask

    task automatic mid_reset(input logic [4:0] ra);
        #2;
        drive_idle();
        raddr_a_i = ra;
        rst_ni    = 1'b0;
        #1;
        chk("rst_rf_we", 64'(rf_we_o), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr_o), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_fwd_a", {31'd0, fwd_a_valid_o, fwd_a_data_o}, 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_ex_ready", 64'(ex_ready_o), 64'd1);
        chk("rst_lsu_ready", 64'(lsu_req_ready_o), 64'd1);
        alu_q.delete();
        pend = 0; lsu_due = 0; err_due = 0; cur_we = 0;
        @(posedge clk_int);
        @(posedge clk_int);
        #3;
        rst_ni = 1'b1;
    endtask

    initial begin
        logic        ev, rq, rv, rerr;
        logic [4:0]  ea, la, ra, rb;
        rst_ni = 1'b0;
        drive_idle();
        raddr_a_i = 0;
        pend = 0; prd = 0; lsu_due = 0; err_due = 0; cur_we = 0; cur = '0; lsu_exp = '0;
        @(posedge clk_int);
        @(posedge clk_int);
        #3;
        rst_ni = 1'b1;
        #1;
        chk("init_rf_we", 64'(rf_we_o), 64'd0);
        chk("init_rf_waddr", 64'(rf_waddr_o), 64'd0);
        chk("init_rf_wdata", 64'(rf_wdata_o), 64'd0);
        chk("init_err", 64'(err_o), 64'd0);
        chk("init_ex_ready", 64'(ex_ready_o), 64'd1);
        chk("init_lsu_ready", 64'(lsu_req_ready_o), 64'd1);

        // Back-to-back execute results, one cycle each to the RF port.
        alu(5, 32'h11);
        alu(6, 32'h22);
        idle(2);

        // Load-use on x7, released once the response is registered.
        step(0, 0, 0, 1, 7, 0, 0, 0, 7, 0);
        idle(3, 7);
        step(0, 0, 0, 0, 0, 1, 32'hDEAD, 0, 7, 0);
        idle(2, 7);

        // Load response racing execute results until the FIFO fills.
        step(0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
        alu(8, 32'h1, 1, 32'hBEEF);
        alu(11, 32'hB, 0, 0, 1, 13);
        alu(12, 32'hC, 1, 32'h1313);
        alu(14, 32'hE, 0, 0, 1, 15);
        alu(9, 32'h9, 1, 32'h1515);
        alu(1, 32'h100);
        idle(4);

        // x0 discard and illegal RV32E destination.
        alu(0, 32'h55);
        alu(20, 32'h66);
        idle(3);

        // WAW hold on x9, then load issue blocked by a queued x3.
        step(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        alu(9, 32'h99);
        alu(9, 32'h99);
        alu(9, 32'h99, 1, 32'h9090);
        alu(9, 32'h98);
        idle(2);
        step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        alu(3, 32'h33, 1, 32'h4444);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 1, 32'h3030, 0, 0, 0);
        idle(2);

        // Erroring load, then reset with the FIFO full.
        step(0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'hBAD, 1, 2, 0);
        step(0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        alu(1, 32'hA1, 1, 32'h6666);
        alu(4, 32'hA4, 0, 0, 1, 7);
        alu(5, 32'hA5, 1, 32'h7777);
        mid_reset(5);
        step(0, 0, 0, 0, 0, 1, 32'hF00D, 0, 0, 0);
        idle(2);

        for (int n = 0; n < 4000; n++) begin
            ev   = ($urandom_range(0, 9) < 6);
            ea   = ($urandom_range(0, 15) == 0) ? 5'(16 + $urandom_range(0, 15))
                                                : 5'($urandom_range(0, 7));
            rq   = ($urandom_range(0, 2) == 0);
            la   = 5'($urandom_range(0, 7));
            rv   = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            rerr = ($urandom_range(0, 9) == 0);
            ra   = 5'($urandom_range(0, 7));
            rb   = 5'($urandom_range(0, 7));
            step(ev, ea, $urandom(), rq, la, rv, $urandom(), rerr, ra, rb);
            if (n % 997 == 500) mid_reset(ra);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
